// File: rtl/stage_ma.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : stage_ma (with package stage_ma_pkg)                       |
// | Description : Memory-access stage of the 5-stage RISC-V pipeline.        |
// |               Takes the EX-MA bundle, issues one request per load/store  |
// |               on a request/response data bus, aligns store lanes,        |
// |               extracts and extends load data, stalls upstream while a    |
// |               transaction is outstanding and registers the MA-WB bundle. |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
// | Ports                                                                    |
// |   clk           in   pipeline clock, rising edge                         |
// |   rst_i         in   synchronous active-high reset                       |
// |   ex_ma_i       in   EX-MA pipeline register bundle                      |
// |   dmem_req_o    out  one-cycle request strobe                            |
// |   dmem_we_o     out  1 = store, 0 = load (valid with req)                |
// |   dmem_addr_o   out  word-aligned address                                |
// |   dmem_be_o     out  byte enables                                        |
// |   dmem_wdata_o  out  lane-replicated store data                          |
// |   dmem_rvalid_i in   response strobe (loads and stores)                  |
// |   dmem_rdata_i  in   load data, valid with rvalid                        |
// |   stall_o       out  hold EX-MA and all upstream stages                  |
// |   misalign_o    out  pulse when a misaligned access is dropped           |
// |   bus_err_o     out  pulse when a transaction times out                  |
// |   ma_wb_reg_o   out  registered MA-WB bundle                             |
// +--------------------------------------------------------------------------+

package stage_ma_pkg;

   typedef struct packed {
      logic        valid;
      logic        dmem_wr_en;
      logic        dmem_rd_en;
      logic [1:0]  dmem_size;      // 00 byte, 01 half, 10 word
      logic        dmem_sign;      // 1 = zero-extend (LBU/LHU)
      logic [31:0] dmem_data;
      logic [31:0] alu_result;     // address for memory ops, result otherwise
      logic [31:0] pc_plus_four;
      logic        reg_wr_en;
      logic        reg_wr_sel;
      logic [4:0]  reg_wr_addr;
   } ex_ma_reg_t;

   typedef struct packed {
      logic        valid;
      logic        reg_wr_en;
      logic        reg_wr_sel;
      logic [4:0]  reg_wr_addr;
      logic [31:0] pc_plus_four;
      logic [31:0] alu_result;
      logic [31:0] load_data;
   } ma_wb_reg_t;

endpackage

module stage_ma
   import stage_ma_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int CNT_W          = 5
) (
   input  logic        clk,
   input  logic        rst_i,
   input  ex_ma_reg_t  ex_ma_i,
   output logic        dmem_req_o,
   output logic        dmem_we_o,
   output logic [31:0] dmem_addr_o,
   output logic [3:0]  dmem_be_o,
   output logic [31:0] dmem_wdata_o,
   input  logic        dmem_rvalid_i,
   input  logic [31:0] dmem_rdata_i,
   output logic        stall_o,
   output logic        misalign_o,
   output logic        bus_err_o,
   output ma_wb_reg_t  ma_wb_reg_o
);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_t;

   // Counter value of the final WAIT cycle; the counter starts at zero in
   // the first WAIT cycle.
   localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   ma_wb_reg_t       r_ma_wb;

   logic             w_mem;
   logic             w_misalign;
   logic             w_in_idle;
   logic             w_in_wait;
   logic             w_issue;
   logic             w_drop;
   logic             w_done;
   logic             w_timeout;
   logic             w_hold;
   logic [1:0]       w_off;
   logic [3:0]       w_be;
   logic [31:0]      w_wdata;
   logic [7:0]       w_byte;
   logic [15:0]      w_half;
   logic [31:0]      w_load;
   state_t           w_state_next;
   logic [CNT_W-1:0] w_cnt_next;
   ma_wb_reg_t       w_ma_wb_next;

   // ---------------------------------------------------------------------
   // Access classification
   // ---------------------------------------------------------------------
   assign w_off      = ex_ma_i.alu_result[1:0];
   assign w_mem      = ex_ma_i.valid & (ex_ma_i.dmem_rd_en | ex_ma_i.dmem_wr_en);
   assign w_misalign = ((ex_ma_i.dmem_size == 2'b01) & w_off[0]) |
                       ((ex_ma_i.dmem_size == 2'b10) & (w_off != 2'b00));

   assign w_in_idle  = (r_state == ST_IDLE);
   assign w_in_wait  = (r_state == ST_WAIT);

   // All control events are masked while reset is asserted so the bus and
   // pipeline controls are quiet during the reset cycle itself.
   assign w_issue    = ~rst_i & w_in_idle & w_mem & ~w_misalign;
   assign w_drop     = ~rst_i & w_in_idle & w_mem &  w_misalign;
   assign w_done     = ~rst_i & w_in_wait & dmem_rvalid_i;
   // A response in the last WAIT cycle takes priority over the timeout.
   assign w_timeout  = ~rst_i & w_in_wait & ~dmem_rvalid_i & (r_cnt == C_CNT_LAST);
   assign w_hold     = ~rst_i & w_in_wait & ~dmem_rvalid_i & ~w_timeout;

   // ---------------------------------------------------------------------
   // Store lane alignment (loads reuse the same byte enables)
   // ---------------------------------------------------------------------
   always_comb begin
      w_be    = 4'b1111;
      w_wdata = ex_ma_i.dmem_data;
      case (ex_ma_i.dmem_size)
         2'b00: begin
            w_be    = 4'b0001 << w_off;
            w_wdata = {4{ex_ma_i.dmem_data[7:0]}};
         end
         2'b01: begin
            w_be    = 4'b0011 << w_off;
            w_wdata = {2{ex_ma_i.dmem_data[15:0]}};
         end
         default: begin
            w_be    = 4'b1111;
            w_wdata = ex_ma_i.dmem_data;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // Load data extraction and extension
   // ---------------------------------------------------------------------
   always_comb begin
      w_byte = dmem_rdata_i[7:0];
      case (w_off)
         2'd0:    w_byte = dmem_rdata_i[7:0];
         2'd1:    w_byte = dmem_rdata_i[15:8];
         2'd2:    w_byte = dmem_rdata_i[23:16];
         default: w_byte = dmem_rdata_i[31:24];
      endcase
   end

   // Aligned halfwords only ever sit at offset 0 or 2.
   assign w_half = w_off[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];

   always_comb begin
      w_load = dmem_rdata_i;
      case (ex_ma_i.dmem_size)
         2'b00:   w_load = ex_ma_i.dmem_sign ? {24'h000000, w_byte}
                                             : {{24{w_byte[7]}}, w_byte};
         2'b01:   w_load = ex_ma_i.dmem_sign ? {16'h0000, w_half}
                                             : {{16{w_half[15]}}, w_half};
         default: w_load = dmem_rdata_i;
      endcase
   end

   // ---------------------------------------------------------------------
   // Next-state, counter and MA-WB bundle
   // ---------------------------------------------------------------------
   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      if (w_issue) begin
         w_state_next = ST_WAIT;
         w_cnt_next   = '0;
      end else if (w_done || w_timeout) begin
         w_state_next = ST_IDLE;
      end else if (w_hold) begin
         w_cnt_next   = r_cnt + CNT_W'(1);
      end
   end

   always_comb begin
      w_ma_wb_next.valid        = ex_ma_i.valid;
      w_ma_wb_next.reg_wr_en    = ex_ma_i.reg_wr_en;
      w_ma_wb_next.reg_wr_sel   = ex_ma_i.reg_wr_sel;
      w_ma_wb_next.reg_wr_addr  = ex_ma_i.reg_wr_addr;
      w_ma_wb_next.pc_plus_four = ex_ma_i.pc_plus_four;
      w_ma_wb_next.alu_result   = ex_ma_i.alu_result;
      w_ma_wb_next.load_data    = 32'h0000_0000;

      // The instruction is still in flight: hand writeback a bubble.
      if (w_issue || w_hold) begin
         w_ma_wb_next.valid = 1'b0;
      end

      // Dropped or abandoned accesses retire without touching the regfile.
      if (w_drop || w_timeout) begin
         w_ma_wb_next.reg_wr_en = 1'b0;
      end

      if (w_done && ex_ma_i.dmem_rd_en) begin
         w_ma_wb_next.load_data = w_load;
      end
   end

   always_ff @(posedge clk) begin
      if (rst_i) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_ma_wb <= '0;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
         r_ma_wb <= w_ma_wb_next;
      end
   end

   // ---------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------
   assign dmem_req_o   = w_issue;
   assign dmem_we_o    = ex_ma_i.dmem_wr_en;
   assign dmem_addr_o  = {ex_ma_i.alu_result[31:2], 2'b00};
   assign dmem_be_o    = w_be;
   assign dmem_wdata_o = w_wdata;

   assign stall_o      = w_issue | w_hold;
   assign misalign_o   = w_drop;
   assign bus_err_o    = w_timeout;
   assign ma_wb_reg_o  = r_ma_wb;

endmodule

`default_nettype wire

// File: tb/tb_stage_ma.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_stage_ma                                                |
// | Description : Scoreboard bench for stage_ma. Directed cases followed by  |
// |               random instruction streams; a memory responder and an      |
// |               MA-WB monitor compare against a behavioural model.         |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+

module tb_stage_ma;
   import stage_ma_pkg::*;

   localparam int TO = 4;
   localparam int CW = 3;

   logic        clk = 1'b0;
   logic        rst_i;
   ex_ma_reg_t  ex_ma_i;
   logic        dmem_req_o;
   logic        dmem_we_o;
   logic [31:0] dmem_addr_o;
   logic [3:0]  dmem_be_o;
   logic [31:0] dmem_wdata_o;
   logic        dmem_rvalid_i;
   logic [31:0] dmem_rdata_i;
   logic        stall_o;
   logic        misalign_o;
   logic        bus_err_o;
   ma_wb_reg_t  ma_wb_reg_o;

   always #5 clk = ~clk;

   stage_ma #(
      .TIMEOUT_CYCLES (TO),
      .CNT_W          (CW)
   ) dut (
      .clk           (clk),
      .rst_i         (rst_i),
      .ex_ma_i       (ex_ma_i),
      .dmem_req_o    (dmem_req_o),
      .dmem_we_o     (dmem_we_o),
      .dmem_addr_o   (dmem_addr_o),
      .dmem_be_o     (dmem_be_o),
      .dmem_wdata_o  (dmem_wdata_o),
      .dmem_rvalid_i (dmem_rvalid_i),
      .dmem_rdata_i  (dmem_rdata_i),
      .stall_o       (stall_o),
      .misalign_o    (misalign_o),
      .bus_err_o     (bus_err_o),
      .ma_wb_reg_o   (ma_wb_reg_o)
   );

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
      int          lat;
      bit          to;
      logic [31:0] rdata;
   } plan_t;

   typedef struct {
      ma_wb_reg_t wb;
      bit         chk_ld;
      bit         mis;
      bit         berr;
      int         stall;
   } exp_t;

   plan_t plan_q[$];
   exp_t  exp_q[$];
   int    n_checks = 0;
   int    n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [31:0] ref_load(input logic [31:0] rd, input logic [1:0] off,
                                            input logic [1:0] sz, input logic zext);
      logic [31:0] v;
      logic [31:0] m;
      int          bits;
      if (sz == 2'd2) return rd;
      bits = (sz == 2'd0) ? 8 : 16;
      m    = (sz == 2'd0) ? 32'h0000_00FF : 32'h0000_FFFF;
      v    = (rd >> (8 * int'(off))) & m;
      if (!zext && v[bits-1]) v = v | ~m;
      return v;
   endfunction

   function automatic logic [3:0] ref_be(input logic [1:0] sz, input logic [1:0] off);
      int v;
      if (sz == 2'd0)      v = 1 << off;
      else if (sz == 2'd1) v = 3 << off;
      else                 v = 15;
      return 4'(v);
   endfunction

   function automatic logic [31:0] ref_wdata(input logic [1:0] sz, input logic [31:0] d);
      if (sz == 2'd0) return {24'h0, d[7:0]} * 32'h0101_0101;
      if (sz == 2'd1) return {16'h0, d[15:0]} * 32'h0001_0001;
      return d;
   endfunction

   function automatic ex_ma_reg_t mk(input logic v, input logic rd, input logic wr,
                                     input logic [1:0] sz, input logic sgn,
                                     input logic [31:0] data, input logic [31:0] addr,
                                     input logic rwe);
      ex_ma_reg_t b;
      b.valid        = v;
      b.dmem_rd_en   = rd;
      b.dmem_wr_en   = wr;
      b.dmem_size    = sz;
      b.dmem_sign    = sgn;
      b.dmem_data    = data;
      b.alu_result   = addr;
      b.pc_plus_four = $urandom;
      b.reg_wr_en    = rwe;
      b.reg_wr_sel   = 1'($urandom);
      b.reg_wr_addr  = 5'($urandom);
      return b;
   endfunction

   // Issue one instruction, record expectations and hold it until accepted.
   task automatic run_op(input ex_ma_reg_t b, input int lat, input bit to, input logic [31:0] rd);
      plan_t p;
      exp_t  e;
      bit    mem;
      bit    mis;
      logic  s;
      int    n;
      mem = b.valid && (b.dmem_rd_en || b.dmem_wr_en);
      mis = (b.dmem_size == 2'd1 && b.alu_result[0]) ||
            (b.dmem_size == 2'd2 && b.alu_result[1:0] != 2'b00);
      if (mem && !mis) begin
         p.we    = b.dmem_wr_en;
         p.addr  = b.alu_result & ~32'h3;
         p.be    = ref_be(b.dmem_size, b.alu_result[1:0]);
         p.wdata = ref_wdata(b.dmem_size, b.dmem_data);
         p.lat   = lat;
         p.to    = to;
         p.rdata = rd;
         plan_q.push_back(p);
      end
      if (b.valid) begin
         e.wb.valid        = 1'b1;
         e.wb.reg_wr_en    = b.reg_wr_en && !(mem && (mis || to));
         e.wb.reg_wr_sel   = b.reg_wr_sel;
         e.wb.reg_wr_addr  = b.reg_wr_addr;
         e.wb.pc_plus_four = b.pc_plus_four;
         e.wb.alu_result   = b.alu_result;
         e.wb.load_data    = 32'h0;
         e.chk_ld          = !mem;
         if (mem && !mis && !to && b.dmem_rd_en) begin
            e.chk_ld       = 1'b1;
            e.wb.load_data = ref_load(rd, b.alu_result[1:0], b.dmem_size, b.dmem_sign);
         end
         e.mis   = mem && mis;
         e.berr  = mem && !mis && to;
         e.stall = (mem && !mis) ? (to ? TO : lat) : 0;
         exp_q.push_back(e);
      end
      ex_ma_i = b;
      n = 0;
      forever begin
         @(negedge clk);
         s = stall_o;
         @(posedge clk);
         n++;
         if (!s) break;
         if (n > 50) begin
            n_checks++;
            n_errors++;
            $display("FAIL accept_bound: stall held %0d cycles, required release", n);
            break;
         end
      end
      #1;
      // Leave room for the stray response that follows an abandoned access.
      if (mem && !mis && to) begin
         ex_ma_i = mk(0, 0, 0, 2'd0, 0, 0, 0, 0);
         repeat (2) @(posedge clk);
         #1;
      end
   endtask

   // ---------------- memory responder ----------------
   initial begin
      plan_t p;
      int    w;
      dmem_rvalid_i = 1'b0;
      dmem_rdata_i  = 32'h0;
      forever begin
         @(negedge clk);
         if (dmem_req_o === 1'b1) begin
            if (plan_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL unexpected_req: got req addr 0x%08h, required no request", dmem_addr_o);
            end else begin
               p = plan_q.pop_front();
               check("req_we",   32'(dmem_we_o), 32'(p.we));
               check("req_addr", dmem_addr_o,    p.addr);
               check("req_be",   32'(dmem_be_o), 32'(p.be));
               if (p.we) check("req_wdata", dmem_wdata_o, p.wdata);
               // Timed-out accesses get a late, stray response.
               w = p.to ? TO + 1 : p.lat;
               for (int i = 1; i < w; i++) begin
                  @(negedge clk);
                  check("req_single", 32'(dmem_req_o), 32'h0);
               end
               @(posedge clk);
               #1;
               dmem_rvalid_i = 1'b1;
               dmem_rdata_i  = p.to ? $urandom : p.rdata;
               @(posedge clk);
               #1;
               dmem_rvalid_i = 1'b0;
               dmem_rdata_i  = $urandom;
            end
         end
      end
   end

   // ---------------- MA-WB monitor ----------------
   initial begin
      exp_t e;
      int   sc = 0;
      logic pm = 1'b0;
      logic pb = 1'b0;
      forever begin
         @(negedge clk);
         if (rst_i) begin
            sc = 0;
         end else if (ma_wb_reg_o.valid === 1'b1) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL unexpected_wb: got valid pc 0x%08h, required bubble", ma_wb_reg_o.pc_plus_four);
            end else begin
               e = exp_q.pop_front();
               check("wb_reg_wr_en",  32'(ma_wb_reg_o.reg_wr_en),   32'(e.wb.reg_wr_en));
               check("wb_reg_wr_sel", 32'(ma_wb_reg_o.reg_wr_sel),  32'(e.wb.reg_wr_sel));
               check("wb_reg_addr",   32'(ma_wb_reg_o.reg_wr_addr), 32'(e.wb.reg_wr_addr));
               check("wb_pc4",        ma_wb_reg_o.pc_plus_four,     e.wb.pc_plus_four);
               check("wb_alu",        ma_wb_reg_o.alu_result,       e.wb.alu_result);
               if (e.chk_ld) check("wb_load_data", ma_wb_reg_o.load_data, e.wb.load_data);
               check("misalign_pulse", 32'(pm), 32'(e.mis));
               check("bus_err_pulse",  32'(pb), 32'(e.berr));
               check("stall_cycles",   32'(sc), 32'(e.stall));
            end
            sc = 0;
         end
         if (stall_o === 1'b1) sc++;
         pm = misalign_o;
         pb = bus_err_o;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      ex_ma_reg_t  b;
      plan_t       p;
      int          kind;
      logic [1:0]  sz;
      logic [31:0] addr;

      rst_i   = 1'b1;
      ex_ma_i = mk(0, 0, 0, 2'd0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_wb_valid", 32'(ma_wb_reg_o.valid), 32'h0);
      check("rst_req",      32'(dmem_req_o),        32'h0);
      check("rst_stall",    32'(stall_o),           32'h0);
      check("rst_misalign", 32'(misalign_o),        32'h0);
      check("rst_bus_err",  32'(bus_err_o),         32'h0);
      @(posedge clk);
      #1;
      rst_i = 1'b0;

      // LW 0x100, response three cycles after the request
      run_op(mk(1, 1, 0, 2'd2, 0, 32'h0, 32'h0000_0100, 1), 3, 0, 32'hDEAD_BEEF);
      // LB / LBU at 0x103 with a one-cycle memory, issued back to back
      run_op(mk(1, 1, 0, 2'd0, 0, 32'h0, 32'h0000_0103, 1), 1, 0, 32'h80FF_00AA);
      run_op(mk(1, 1, 0, 2'd0, 1, 32'h0, 32'h0000_0103, 1), 1, 0, 32'h80FF_00AA);
      // SH 0x102
      run_op(mk(1, 0, 1, 2'd1, 0, 32'h1234_ABCD, 32'h0000_0102, 0), 2, 0, 32'h0);
      // misaligned LW
      run_op(mk(1, 1, 0, 2'd2, 0, 32'h0, 32'h0000_0101, 1), 1, 0, 32'h0);
      // LW with no response, then a late stray response
      run_op(mk(1, 1, 0, 2'd2, 0, 32'h0, 32'h0000_0200, 1), 1, 1, 32'h0);
      // response arriving in the very last WAIT cycle
      run_op(mk(1, 1, 0, 2'd1, 0, 32'h0, 32'h0000_0302, 1), TO, 0, 32'h8001_7FFF);
      // invalid bundle with memory enables set
      run_op(mk(0, 1, 1, 2'd2, 0, 32'h0, 32'h0000_0400, 1), 1, 0, 32'h0);

      // reset during the second WAIT cycle
      b       = mk(1, 1, 0, 2'd2, 0, 32'h0, 32'h0000_0500, 1);
      p.we    = 1'b0;
      p.addr  = 32'h0000_0500;
      p.be    = 4'hF;
      p.wdata = 32'h0;
      p.lat   = 5;
      p.to    = 1'b0;
      p.rdata = 32'h1111_2222;
      plan_q.push_back(p);
      ex_ma_i = b;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      rst_i   = 1'b1;
      ex_ma_i = mk(0, 0, 0, 2'd0, 0, 0, 0, 0);
      @(posedge clk);
      #1;
      rst_i = 1'b0;
      @(negedge clk);
      check("post_rst_stall",    32'(stall_o),           32'h0);
      check("post_rst_wb_valid", 32'(ma_wb_reg_o.valid), 32'h0);
      @(posedge clk);
      #1;
      run_op(mk(1, 0, 0, 2'd0, 0, 32'h0, 32'h0000_0042, 1), 1, 0, 32'h0);
      @(negedge clk);
      check("add_latency_valid", 32'(ma_wb_reg_o.valid), 32'h1);
      ex_ma_i = mk(0, 0, 0, 2'd0, 0, 0, 0, 0);
      repeat (3) @(posedge clk);
      #1;

      // random instruction stream
      repeat (250) begin
         kind = $urandom_range(0, 9);
         sz   = 2'($urandom_range(0, 2));
         addr = $urandom;
         if ($urandom_range(0, 3) != 0) begin
            if (sz == 2'd2) addr[1:0] = 2'b00;
            if (sz == 2'd1) addr[0]   = 1'b0;
         end
         if (kind <= 2)
            b = mk(1, 0, 0, sz, 1'($urandom), $urandom, addr, 1'($urandom));
         else if (kind == 3)
            b = mk(0, 1'($urandom), 1'($urandom), sz, 0, $urandom, addr, 1'($urandom));
         else if (kind <= 6)
            b = mk(1, 1, 0, sz, 1'($urandom), $urandom, addr, 1'($urandom));
         else
            b = mk(1, 0, 1, sz, 1'($urandom), $urandom, addr, 1'($urandom));
         run_op(b, $urandom_range(1, TO), ($urandom_range(0, 9) == 0), $urandom);
      end

      ex_ma_i = mk(0, 0, 0, 2'd0, 0, 0, 0, 0);
      repeat (10) @(posedge clk);
      check("exp_queue_drained",  32'(exp_q.size()),  32'h0);
      check("plan_queue_drained", 32'(plan_q.size()), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/stage_ma.md
Name: stage_ma

Overview:
- Memory-access stage of the 5-stage RISC-V pipeline. Sits between the EX-MA and MA-WB pipeline registers.
- Consumes the registered EX-MA bundle and drives a request/response data-memory bus. Byte lanes are aligned, and load data is extracted and sign/zero-extended.
- Holds the upstream pipeline (stall_o) while a memory transaction is outstanding.
- Produces the registered MA-WB bundle for writeback.

Parameters:
- TIMEOUT_CYCLES, 16: maximum number of WAIT cycles before a transaction is abandoned as a bus error (must be ≥2).
- CNT_W, 5: width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- rst_i  input  1  synchronous, active-high reset.
- ex_ma_i  input  ex_ma_reg_t  EX-MA register.
  - Fields: valid, dmem_wr_en, dmem_rd_en, dmem_size[1:0], dmem_sign, dmem_data[31:0], alu_result[31:0] (address/result), pc_plus_four[31:0], reg_wr_en, reg_wr_sel, reg_wr_addr[4:0].
- dmem_req_o  output  1  request strobe; asserted for exactly one cycle per transaction.
- dmem_we_o  output  1  1 = store, 0 = load; valid with req.
- dmem_addr_o  output  32  word address, {alu_result[31:2], 2'b00}.
- dmem_be_o  output  4  byte enables.
- dmem_wdata_o  output  32  lane-replicated store data.
- dmem_rvalid_i  input  1  response strobe for both loads and stores; arrives ≥1 cycle after req.
- dmem_rdata_i  input  32  load data; valid with rvalid.
- stall_o  output  1  hold EX-MA and all upstream stages.
- misalign_o  output  1  one-cycle pulse when a misaligned access is dropped.
- bus_err_o  output  1  one-cycle pulse on timeout.
- ma_wb_reg_o  output  ma_wb_reg_t  registered output.
  - Fields: valid, reg_wr_en, reg_wr_sel, reg_wr_addr, pc_plus_four, alu_result, load_data[31:0].

Behaviour:
- Access classification:
  - mem = valid & (dmem_rd_en | dmem_wr_en).
  - Misaligned when:
    - size=01 (halfword) and addr[0]=1, or
    - size=10 (word) and addr[1:0]≠00.
- FSM states: IDLE, WAIT.
- IDLE:
  - mem & aligned: drive req=1 combinationally (we=dmem_wr_en), go to WAIT, clear counter. stall_o=1 in the same cycle.
  - mem & misaligned:
    - No req. misalign_o=1.
    - MA-WB gets valid=1 with reg_wr_en=0, so the instruction retires with no effect.
  - Otherwise: MA-WB loads the bundle; load_data=0.
  - Latency for non-memory instructions: 1 cycle, no stall.
- WAIT:
  - req=0, stall_o=1, counter increments every cycle. MA-WB receives a bubble (valid=0).
  - rvalid=1:
    - stall_o=0 in that cycle (combinational).
    - MA-WB captures the bundle plus the extracted load_data.
    - Return to IDLE.
  - Counter reaches TIMEOUT_CYCLES-1 without rvalid:
    - bus_err_o=1, stall_o=0.
    - MA-WB captures the bundle with reg_wr_en=0.
    - Return to IDLE.
  - rvalid and timeout in the same cycle: rvalid wins, no bus_err.
- Store lanes:
  - Byte: be=0001<<addr[1:0], wdata={4{data[7:0]}}.
  - Half: be=0011<<addr[1:0], wdata={2{data[15:0]}}.
  - Word: be=1111, wdata=data.
  - Loads use the same be.
- Load extraction:
  - Select the byte/half at addr[1:0] from rdata.
  - dmem_sign=0: sign-extend. dmem_sign=1 (LBU/LHU): zero-extend.
  - Word: rdata unchanged.
- Stray rvalid in IDLE is ignored.
- Back-to-back memory ops:
  - The next op is issued the cycle after rvalid, once EX-MA has advanced.
  - Max throughput is one memory op per 2 cycles with a 1-cycle memory.
- Reset:
  - FSM→IDLE, counter=0.
  - MA-WB valid=0; other MA-WB fields don't-care.
  - req=0, stall_o=0, misalign_o=0, bus_err_o=0.
  - Reset in WAIT abandons the transaction; a later rvalid is ignored.
- Invalid bundles (valid=0) never issue req, even if rd/wr enables are set.

Test Plan:
- LW addr 0x100, rdata=0xDEADBEEF with rvalid 3 cycles after req:
  - req for exactly 1 cycle, addr=0x100, be=1111.
  - stall_o high 3 cycles; MA-WB bubbles.
  - Then MA-WB valid, load_data=0xDEADBEEF.
- LB vs LBU at addr 0x103, rdata=0x80FF00AA, rvalid next cycle:
  - be=1000.
  - LB → load_data=0xFFFFFF80; LBU → 0x00000080.
- SH addr 0x102, data=0x1234ABCD:
  - we=1, be=1100, wdata=0xABCDABCD.
  - After rvalid, MA-WB valid with reg_wr_en=0 passed through.
- LW addr 0x101: no req, misalign_o pulse, MA-WB valid=1 with reg_wr_en=0, no stall.
- LW with no rvalid, TIMEOUT_CYCLES=4:
  - stall_o high 4 cycles (the req cycle plus 3 WAIT cycles).
  - bus_err_o pulse in the last WAIT cycle, stall released.
  - A later rvalid is ignored.
- rst_i asserted in WAIT cycle 2:
  - Next cycle IDLE, stall_o=0, MA-WB valid=0.
  - An ADD following reset passes with 1-cycle latency.
